instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Parametrised instruction fetch stage for the single-cycle/multi-cycle MIPS core. It holds the PC, reads a loadable on-chip instruction memory of DEPTH words with one-cycle synchronous latency, and buffers results in a small prefetch FIFO. The FIFO presents instruction and PC to decode over a valid/ready handshake. Supports branch/jump redirect with flush, and backpressure from decode.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 64, instruction memory depth in words (power of two not required)
FIFO_DEPTH, 2, prefetch buffer entries (>=2)
RESET_PC, 0, word index loaded into PC at reset
NOP_INSTR, 32'h00000000, instruction substituted for out-of-range fetches

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
fetch_en  in  1  allow new memory reads
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  new PC (word index)
out_valid  out  1  head FIFO entry valid
out_ready  in  1  decode accepts head entry
out_instr  out  DATA_W  head instruction
out_pc  out  32  PC (word index) of head instruction
out_err  out  1  head entry came from out-of-range PC
load_we  in  1  program-load write strobe
load_addr  in  $clog2(DEPTH)  program-load word address
load_data  in  DATA_W  program-load data
busy  out  1  read in flight or FIFO non-empty

Behaviour:
- Reset (rst low, async): pc=RESET_PC, FIFO empty, in-flight cleared; out_valid=0, out_instr=0, out_pc=0, out_err=0, busy=0. Memory contents not reset.
- PC is a word index; increments by 1; 32'hFFFFFFFF wraps to 0.
- Issue: in cycle N if fetch_en=1, redirect_valid=0, and (fifo_count + inflight) < FIFO_DEPTH, read mem[pc], tag with pc, pc<=pc+1, inflight<=1 at edge N.
- Return: in cycle N+1 the read data + tag + err are pushed into the FIFO at the edge ending N+1; out_valid high in cycle N+2. Issue-to-visible latency = 2 edges.
- Slot reservation counts the in-flight read, so the FIFO never overflows; push into a full FIFO cannot occur.
- Out-of-range: pc >= DEPTH -> no array read; entry carries NOP_INSTR and err=1. No other side effect; fetch continues.
- Output: out_* reflect FIFO head (show-ahead). Pop when out_valid && out_ready. Push and pop same cycle keeps count unchanged.
- Throughput: with out_ready held 1 and fetch_en 1, one instruction per cycle sustained after initial latency.
- Backpressure: out_ready=0 holds out_* stable; issue stops once reservation is full; pc does not advance.
- Redirect (redirect_valid=1 in cycle R): pc<=redirect_pc; FIFO flushed; in-flight read discarded (not pushed); no issue in cycle R. A handshake on the head in cycle R counts as accepted; all other entries dropped. First redirected instruction visible in cycle R+3.
- fetch_en=0: no new issues; in-flight read still completes into FIFO; FIFO still drains.
- Load port: load_we writes mem[load_addr]<=load_data at edge. Same-cycle read of same address returns old data (read-before-write). Writes while fetch_en=1 are legal but fetched results are software's responsibility.
- busy = inflight | (fifo_count != 0).

Optional Feature:
IFETCH_PERF_CNT_EN: when defined, adds outputs perf_fetched (32) counting pushes into the FIFO and perf_stall (32) counting cycles with fetch_en=1 and no issue due to full reservation; both reset to 0, saturate at 32'hFFFFFFFF, redirect-discarded reads not counted. When undefined, ports and logic are absent; all other behaviour identical.

Test Plan:
Load mem[0..3]=00001020,20220004,8C010001,AC010001; release reset, fetch_en=1, out_ready=1 -> out_valid rises 2 edges after first issue, outputs pc 0,1,2,3 with those words on consecutive cycles.
Hold out_ready=0 after first entry -> FIFO fills to FIFO_DEPTH, pc stops advancing, out_instr stays 00001020; release -> stream resumes with pc 1 next, no loss or duplicate.
Redirect to pc=2 while entries pc 0,1 buffered and read in flight -> flush; next visible entry pc=2, instr 8C010001, 3 cycles after redirect.
Redirect_pc=DEPTH+5 -> out_instr=NOP_INSTR, out_err=1, out_pc=DEPTH+5, then DEPTH+6.
Assert rst low mid-stream with FIFO full -> immediately out_valid=0, busy=0; after release fetch restarts at RESET_PC.
With IFETCH_PERF_CNT_EN, 10 instructions, out_ready low 5 cycles -> perf_fetched=10 plus buffered count, perf_stall equals stalled cycles.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch stage: program counter, loadable instruction memory with
// one-cycle registered read, and a show-ahead prefetch FIFO that hands
// {instr, pc, err} to decode over a valid/ready handshake.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   fetch_en       in   allow new memory reads
//   redirect_valid in   branch/jump taken this cycle (flushes the pipe)
//   redirect_pc    in   new PC (word index)
//   out_valid      out  FIFO head valid
//   out_ready      in   decode accepts FIFO head
//   out_instr      out  head instruction (0 when empty)
//   out_pc         out  head PC, word index (0 when empty)
//   out_err        out  head came from an out-of-range PC (0 when empty)
//   load_we        in   program-load write strobe
//   load_addr      in   program-load word address
//   load_data      in   program-load data
//   busy           out  read in flight or FIFO non-empty
//   perf_fetched   out  (IFETCH_PERF_CNT_EN only) saturating FIFO push count
//   perf_stall     out  (IFETCH_PERF_CNT_EN only) saturating count of cycles
//                       fetch was wanted but the reservation was full
//
// Optional feature macro: IFETCH_PERF_CNT_EN
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 64,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [31:0]       RESET_PC   = 32'd0,
    parameter logic [DATA_W-1:0] NOP_INSTR  = '0,
    localparam int               AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [31:0]       out_pc,
    output logic              out_err,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]       pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [31:0]       infl_pc_q;
    logic              infl_err_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [31:0]       fifo_pc_q    [FIFO_DEPTH];
    logic              fifo_err_q   [FIFO_DEPTH];

    logic          pc_in_range;
    logic          pop, push, issue;
    logic [CW:0]   reserved;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pc_in_range = (pc_q < 32'(DEPTH));
    assign pop         = out_valid && out_ready;
    // The returning read always lands unless a redirect discards it.
    assign push        = inflight_q && !redirect_valid;
    // Slots taken = buffered + in flight; a head being popped this cycle frees
    // its slot, which is what allows one fetch per cycle with a 2-entry FIFO.
    assign reserved    = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue       = fetch_en && !redirect_valid && (reserved < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        pc_d       = pc_q;
        inflight_d = issue;
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else if (issue) begin
            pc_d = pc_q + 32'd1;  // 32'hFFFFFFFF wraps to 0
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            infl_pc_q  <= '0;
            infl_err_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (issue) begin
                infl_pc_q  <= pc_q;
                infl_err_q <= !pc_in_range;
            end
        end
    end

    // Instruction memory: contents are not reset. Read and write share one
    // process so a same-address read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (load_we && (32'(load_addr) < 32'(DEPTH)))
            mem[load_addr] <= load_data;
        if (issue && pc_in_range)
            rd_data_q <= mem[pc_q[AW-1:0]];
    end

    // Prefetch FIFO storage; validity is tracked by count_q, so no reset.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    fifo_instr_q[gi] <= infl_err_q ? NOP_INSTR : rd_data_q;
                    fifo_pc_q[gi]    <= infl_pc_q;
                    fifo_err_q[gi]   <= infl_err_q;
                end
            end
        end
    endgenerate

    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign out_err   = out_valid ? fifo_err_q[rd_ptr_q]   : 1'b0;
    assign busy      = inflight_q | out_valid;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    logic        stall_cycle;

    // Redirect cycles are excluded: the missing issue there is due to the
    // redirect, and the discarded read never reaches push.
    assign stall_cycle = fetch_en && !redirect_valid && !issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push && (perf_fetched_q != 32'hFFFFFFFF))
                perf_fetched_q <= perf_fetched_q + 32'd1;
            if (stall_cycle && (perf_stall_q != 32'hFFFFFFFF))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. Stimulus pushes the expected
// {pc, instr, err} stream into a queue; a monitor pops and compares on every
// output handshake. Latency, hold, redirect and reset timing are checked
// directly at the negative edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int          DW    = 32;
    localparam int          DEP   = 16;
    localparam int          FDEP  = 4;
    localparam logic [31:0] NOP   = 32'hDEAD0001;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            fetch_en = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [31:0]     redirect_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_instr;
    logic [31:0]     out_pc;
    logic            out_err;
    logic            load_we = 1'b0;
    logic [3:0]      load_addr = '0;
    logic [DW-1:0]   load_data = '0;
    logic            busy;

    instr_fetch_unit #(
        .DATA_W     (DW),
        .DEPTH      (DEP),
        .FIFO_DEPTH (FDEP),
        .RESET_PC   (32'd0),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_err        (out_err),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] img [DEP];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.err   = (pc >= 32'(DEP));
        e.instr = e.err ? NOP : img[pc[3:0]];
        return e;
    endfunction

    task automatic push_exp(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(mk_exp(start + 32'(i)));
    endtask

    // Monitor: every handshake must match the next expected entry.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %h instr %h, expected none", out_pc, out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn pc=%h instr=%h err=%0d", out_pc, out_instr, out_err);
                check("mon_pc", out_pc, e.pc);
                check("mon_instr", out_instr, e.instr);
                check("mon_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b0;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        next_cycle();
        next_cycle();
        exp_q.delete();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        fetch_en  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 60 && busy; k++) @(negedge clk);
        check({name, "_drain_busy"}, 32'(busy), 32'd0);
        check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        img[0] = 32'h00001020;
        img[1] = 32'h20220004;
        img[2] = 32'h8C010001;
        img[3] = 32'hAC010001;
        for (int i = 4; i < DEP; i++) img[i] = 32'h10000000 | 32'(i);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < DEP; i++) begin
            next_cycle();
            load_we = 1'b1;
            load_addr = 4'(i);
            load_data = img[i];
        end
        next_cycle();
        load_we = 1'b0;
        @(negedge clk);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // A: latency and one-per-cycle streaming, 8 issues
        do_reset();
        push_exp(0, 8);
        fetch_en = 1'b1; out_ready = 1'b1;           // c0
        @(negedge clk); check("lat_c0_valid", 32'(out_valid), 32'd0);
        next_cycle();                                // c1
        @(negedge clk); check("lat_c1_valid", 32'(out_valid), 32'd0);
        next_cycle();                                // c2
        @(negedge clk); check("lat_c2_valid", 32'(out_valid), 32'd1);
        check("lat_c2_pc", out_pc, 32'd0);
        for (int i = 1; i < 4; i++) begin            // c3..c5
            next_cycle();
            @(negedge clk);
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", out_pc, 32'(i));
        end
        next_cycle(); next_cycle();                  // c6, c7
        next_cycle();                                // c8
        drain("A");

        // B: backpressure fills FIFO, head held, then resume
        do_reset();
        push_exp(0, 8);
        fetch_en = 1'b1; out_ready = 1'b0;           // c0
        repeat (5) next_cycle();                     // c5
        for (int i = 0; i < 3; i++) begin            // c5..c7
            @(negedge clk);
            check("hold_instr", out_instr, 32'h00001020);
            check("hold_pc", out_pc, 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            next_cycle();
        end
        out_ready = 1'b1;                            // c8
        next_cycle();                                // c9
        @(negedge clk); check("resume_pc1", out_pc, 32'd1);
        next_cycle(); next_cycle();                  // c10, c11
        next_cycle();                                // c12
        drain("B");

        // C: redirect to 2 with pc0/pc1 buffered and pc2 in flight
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b0;           // c0
        next_cycle(); next_cycle();                  // c2
        next_cycle();                                // c3 = R
        redirect_valid = 1'b1; redirect_pc = 32'd2;
        @(negedge clk); check("pre_redir_pc", out_pc, 32'd0);
        next_cycle();                                // c4
        redirect_valid = 1'b0;
        exp_q.delete();
        push_exp(2, 3);
        @(negedge clk); check("flush_r1_valid", 32'(out_valid), 32'd0);
        next_cycle();                                // c5
        @(negedge clk); check("flush_r2_valid", 32'(out_valid), 32'd0);
        next_cycle();                                // c6 = R+3
        @(negedge clk);
        check("redir_r3_valid", 32'(out_valid), 32'd1);
        check("redir_r3_pc", out_pc, 32'd2);
        check("redir_r3_instr", out_instr, 32'h8C010001);
        next_cycle();                                // c7
        drain("C");

        // D: out-of-range redirect, then 32-bit PC wrap
        do_reset();
        push_exp(DEP + 5, 2);
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'(DEP + 5);   // R
        next_cycle();
        redirect_valid = 1'b0; fetch_en = 1'b1;
        next_cycle();
        next_cycle();                                // R+3
        fetch_en = 1'b0;
        @(negedge clk);
        check("oor_valid", 32'(out_valid), 32'd1);
        check("oor_pc", out_pc, 32'(DEP + 5));
        check("oor_err", 32'(out_err), 32'd1);
        check("oor_instr", out_instr, NOP);
        drain("D");
        next_cycle();
        exp_q.push_back(mk_exp(32'hFFFFFFFF));
        exp_q.push_back(mk_exp(32'h00000000));
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
        next_cycle();
        redirect_valid = 1'b0; fetch_en = 1'b1;
        next_cycle();
        next_cycle();
        drain("wrap");

        // E: async reset with FIFO full, restart at RESET_PC
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        repeat (6) next_cycle();
        @(negedge clk);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_pc", out_pc, 32'd0);
        exp_q.delete();
        out_ready = 1'b1;
        next_cycle(); next_cycle();
        push_exp(0, 4);
        rst = 1'b1;                                  // c0 issues pc0
        repeat (3) next_cycle();                     // c1..c3
        next_cycle();                                // c4
        drain("E");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
